sevenseg_scan_ctrl: RTL and testbench

Wishbone-configured scan scheduler for a multiplexed common-segment seven-segment display. It time-shares the single 8-bit segment bus among NUM_DIGITS digit enables, with programmable slot length and fixed blanking between digits to suppress ghosting. It sits inside the user project, between the management-SoC Wishbone slave port and the GPIO io_out/io_oeb pads.

---
 rtl/sevenseg_pkg.sv | 32 +++
 rtl/sevenseg_wb_regs.sv | 78 +++++++
 rtl/sevenseg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared register map, scan state encoding and hex font for the seven-segment scanner
package sevenseg_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_PRESC = 2'd1;
  localparam logic [1:0] REG_DLO   = 2'd2;
  localparam logic [1:0] REG_DHI   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_DECODE  = 1;
  localparam int CTRL_SEG_INV = 2;
  localparam int CTRL_DIG_INV = 3;

  localparam logic [3:0] CTRL_RST = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  // Segment order {g,f,e,d,c,b,a}; entry 15 first so SEG_FONT[n] is glyph n.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [7:0] digit_segments(input logic [7:0] digit_byte, input logic decode);
    return decode ? {digit_byte[7], SEG_FONT[digit_byte[3:0]]} : digit_byte;
  endfunction

endpackage

// File: rtl/sevenseg_wb_regs.sv
// rtl/sevenseg_wb_regs.sv - Wishbone decode, single-cycle-gap ack and byte-enabled register file
module sevenseg_wb_regs
  import sevenseg_pkg::*;
#(
  parameter int          NUM_DIGITS = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [15:0] PRESC_RST  = 16'd999
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  ctrl_next,
  output logic [15:0] presc,
  output logic [63:0] digit_data
);

  logic        hit;
  logic        wr;
  logic [1:0]  offset;
  logic [3:0]  ctrl_q;
  logic [31:0] rdata;
  logic        unused_adr;

  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr         = hit & ~wbs_ack_o & wbs_we_i;
  assign offset     = wbs_adr_i[3:2];
  assign unused_adr = ^wbs_adr_i[1:0];

  // The scan FSM sees the CTRL value that commits on this edge, so a disable
  // written on a slot boundary stops the scan instead of advancing it.
  always_comb begin
    ctrl_next = ctrl_q;
    if (wr && offset == REG_CTRL && wbs_sel_i[0]) ctrl_next = wbs_dat_i[3:0];
  end

  always_comb begin
    rdata = '0;
    case (offset)
      REG_CTRL:  rdata = {28'd0, ctrl_q};
      REG_PRESC: rdata = {16'd0, presc};
      REG_DLO:   rdata = digit_data[31:0];
      REG_DHI:   rdata = digit_data[63:32];
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ctrl_q     <= CTRL_RST;
      presc      <= PRESC_RST;
      digit_data <= '0;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (hit & ~wbs_ack_o) ? rdata : '0;
      ctrl_q    <= ctrl_next;
      if (wr && offset == REG_PRESC) begin
        if (wbs_sel_i[0]) presc[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) presc[15:8] <= wbs_dat_i[15:8];
      end
      if (wr) begin
        for (int b = 0; b < 8; b++) begin
          if (b < NUM_DIGITS && offset == ((b < 4) ? REG_DLO : REG_DHI) && wbs_sel_i[b % 4])
            digit_data[b*8 +: 8] <= wbs_dat_i[(b % 4)*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed seven-segment scan scheduler with Wishbone registers and registered pads
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int          NUM_DIGITS   = 8,
  parameter int          BLANK_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [15:0] PRESC_RST    = 16'd999
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic [8+NUM_DIGITS-1:0] disp_oeb_o
);

  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  logic [3:0]      ctrl_next;
  logic [15:0]     presc;
  logic [63:0]     digit_data;
  logic            en;
  scan_state_t     state;
  logic [2:0]      idx;
  logic [2:0]      idx_next;
  logic [15:0]     cnt;
  logic [15:0]     presc_q;
  logic [7:0]      shadow;
  logic [7:0]      raw_seg;
  logic [NUM_DIGITS-1:0] raw_dig;

  sevenseg_wb_regs #(
    .NUM_DIGITS (NUM_DIGITS),
    .BASE_ADDR  (BASE_ADDR),
    .PRESC_RST  (PRESC_RST)
  ) u_regs (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .ctrl_next  (ctrl_next),
    .presc      (presc),
    .digit_data (digit_data)
  );

  assign en       = ctrl_next[CTRL_EN];
  assign idx_next = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;

  always_comb begin
    raw_seg = (state == ST_SHOW) ? shadow : 8'd0;
    raw_dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++) raw_dig[i] = (state == ST_SHOW) && (idx == 3'(i));
  end

  // Digit data, decode mode and slot length are captured only when a slot begins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      presc_q <= '0;
      shadow  <= '0;
    end else if (!en) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_SHOW;
          idx     <= '0;
          cnt     <= '0;
          presc_q <= presc;
          shadow  <= digit_segments(digit_data[7:0], ctrl_next[CTRL_DECODE]);
        end
        ST_SHOW: begin
          if (cnt == presc_q) begin
            state <= ST_BLANK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state   <= ST_SHOW;
            idx     <= idx_next;
            cnt     <= '0;
            presc_q <= presc;
            shadow  <= digit_segments(digit_data[{idx_next, 3'b000} +: 8], ctrl_next[CTRL_DECODE]);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      seg_o      <= '0;
      dig_o      <= '0;
      disp_oeb_o <= '1;
    end else begin
      seg_o      <= raw_seg ^ {8{ctrl_next[CTRL_SEG_INV]}};
      dig_o      <= raw_dig ^ {NUM_DIGITS{ctrl_next[CTRL_DIG_INV]}};
      disp_oeb_o <= {(8+NUM_DIGITS){~en}};
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - directed self-checking bench for sevenseg_scan_ctrl
module tb_sevenseg_scan_ctrl;

  localparam logic [31:0] A_CTRL  = 32'h3000_0000;
  localparam logic [31:0] A_PRESC = 32'h3000_0004;
  localparam logic [31:0] A_DLO   = 32'h3000_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_w = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [7:0]  seg;
  logic [7:0]  dig;
  logic [15:0] oeb;

  int n_tests = 0;
  int n_fail  = 0;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (8),
    .BLANK_CYCLES (4),
    .BASE_ADDR    (32'h3000_0000),
    .PRESC_RST    (16'd999)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_dat_i  (dat_w),
    .wbs_adr_i  (adr),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_r),
    .seg_o      (seg),
    .dig_o      (dig),
    .disp_oeb_o (oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pins(input string tag, input logic [7:0] exp_dig, input logic [7:0] exp_seg);
    chk(tag, {16'd0, dig, seg}, {16'd0, exp_dig, exp_seg});
  endtask

  // Called at a negedge; returns at the negedge right after the commit edge.
  task automatic wb_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic w, output logic [31:0] q);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) break;
    end
    chk(w ? "wr_ack" : "rd_ack", {31'd0, ack}, 32'd1);
    q = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb_access(a, d, s, 1'b1, q);
  endtask

  task automatic wb_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_access(a, 32'd0, 4'hF, 1'b0, q);
    chk(tag, q, exp);
  endtask

  initial begin
    int          d;
    logic        show;
    logic [7:0]  ed, es;

    repeat (2) @(negedge clk);
    pins("reset_pins", 8'h00, 8'h00);
    chk("reset_oeb", {16'd0, oeb}, 32'h0000_FFFF);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_dat", dat_r, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read_chk("rd_ctrl_rst", A_CTRL, 32'h2);
    wb_read_chk("rd_presc_rst", A_PRESC, 32'd999);
    wb_read_chk("rd_dlo_rst", A_DLO, 32'd0);

    // 4-cycle slots, 4 blanking cycles: 8-cycle period, 64 cycles per full sweep
    wb_write(A_PRESC, 32'd3, 4'hF);
    wb_write(A_DLO, 32'h0000_0201, 4'hF);
    wb_write(A_CTRL, 32'h3, 4'hF);
    chk("oeb_en", {16'd0, oeb}, 32'd0);
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      d    = ((k - 1) / 8) % 8;
      show = ((k - 1) % 8) < 4;
      ed   = show ? 8'(1 << d) : 8'h00;
      es   = show ? ((d == 0) ? 8'h06 : (d == 1) ? 8'h5B : 8'h3F) : 8'h00;
      pins("scan", ed, es);
    end
    wb_write(A_CTRL, 32'h2, 4'hF);

    // disable while SHOW
    wb_write(A_CTRL, 32'h3, 4'hF);
    @(negedge clk);
    pins("restart_d0", 8'h01, 8'h06);
    @(negedge clk);
    wb_write(A_CTRL, 32'h2, 4'hF);
    @(negedge clk);
    pins("dis_show_pins", 8'h00, 8'h00);
    chk("dis_show_oeb", {16'd0, oeb}, 32'h0000_FFFF);

    // disable while BLANK, re-enable restarts at digit 0
    wb_write(A_CTRL, 32'h3, 4'hF);
    repeat (5) @(negedge clk);
    pins("blank_pins", 8'h00, 8'h00);
    chk("blank_oeb", {16'd0, oeb}, 32'd0);
    wb_write(A_CTRL, 32'h2, 4'hF);
    @(negedge clk);
    pins("dis_blank_pins", 8'h00, 8'h00);
    chk("dis_blank_oeb", {16'd0, oeb}, 32'h0000_FFFF);
    wb_write(A_CTRL, 32'h3, 4'hF);
    @(negedge clk);
    pins("reen_d0", 8'h01, 8'h06);
    wb_write(A_CTRL, 32'h2, 4'hF);

    // byte lanes and mid-slot shadowing
    wb_write(A_DLO, 32'h0000_7F00, 4'b0010);
    wb_read_chk("rd_dlo_lane", A_DLO, 32'h0000_7F01);
    wb_write(A_CTRL, 32'h3, 4'hF);
    repeat (2) @(negedge clk);
    pins("mid_before", 8'h01, 8'h06);
    wb_write(A_DLO, 32'h0000_0008, 4'b0001);
    pins("mid_held_a", 8'h01, 8'h06);
    @(negedge clk);
    pins("mid_held_b", 8'h01, 8'h06);
    repeat (5) @(negedge clk);
    pins("d1_font_f", 8'h02, 8'h71);
    repeat (56) @(negedge clk);
    pins("mid_next_slot", 8'h01, 8'h7F);
    wb_write(A_CTRL, 32'h2, 4'hF);

    // raw mode with both polarities inverted
    wb_write(A_DLO, 32'h0000_0080, 4'b0001);
    wb_write(A_CTRL, 32'hD, 4'hF);
    @(negedge clk);
    pins("inv_show", 8'hFE, 8'h7F);
    repeat (4) @(negedge clk);
    pins("inv_blank", 8'hFF, 8'hFF);
    wb_write(A_CTRL, 32'h2, 4'hF);

    // held strobe acks every other cycle
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CTRL; sel = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("held_ack", {31'd0, ack}, {31'd0, 1'(k % 2)});
    end
    adr = 32'h3000_0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("offbase_ack", {31'd0, ack}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of a slot
    wb_write(A_CTRL, 32'h3, 4'hF);
    repeat (2) @(negedge clk);
    pins("pre_rst", 8'h01, 8'hBF);
    #2 rst_n = 1'b0;
    #1;
    pins("async_rst_pins", 8'h00, 8'h00);
    chk("async_rst_oeb", {16'd0, oeb}, 32'h0000_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read_chk("rd_ctrl_after_rst", A_CTRL, 32'h2);
    wb_read_chk("rd_dlo_after_rst", A_DLO, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
